// File: rtl/gbuff_pkg.sv
// Shared definitions for the global-buffer read initiator: state encoding,
// skid FIFO geometry and default buffer widths.
package gbuff_pkg;

    localparam int GB_ADDR_BITS  = 8;
    localparam int GB_DATA_BITS  = 8;

    // Two entries cover the one word in flight plus the one waiting at the head.
    localparam int FIFO_DEPTH    = 2;
    localparam int FIFO_PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_BITS = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_BITS      = FIFO_CNT_BITS + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/gbuff_skid_fifo.sv
// Small skid FIFO holding returned buffer words (data plus last tag) until the
// stream consumer takes them; simultaneous push and pop are supported.
module gbuff_skid_fifo
    import gbuff_pkg::*;
#(
    parameter int DATA_BITS = GB_DATA_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DATA_BITS-1:0]     push_data_i,
    input  logic                     push_last_i,
    input  logic                     pop_i,
    output logic [FIFO_CNT_BITS-1:0] count_o,
    output logic [DATA_BITS-1:0]     head_data_o,
    output logic                     head_last_o
);

    logic [DATA_BITS-1:0]     data_q [FIFO_DEPTH];
    logic                     last_q [FIFO_DEPTH];
    logic [FIFO_PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_CNT_BITS-1:0] count_q, count_d;
    logic [FIFO_DEPTH-1:0]    wr_en;
    logic                     do_push;
    logic                     do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign do_push = push_i && ((count_q != FIFO_CNT_BITS'(FIFO_DEPTH)) || do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = do_push && (wr_ptr_q == FIFO_PTR_BITS'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (rst) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end else if (wr_en[i]) begin
                data_q[i] <= push_data_i;
                last_q[i] <= push_last_i;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + FIFO_PTR_BITS'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_PTR_BITS'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + FIFO_CNT_BITS'(1);
            2'b01:   count_d = count_q - FIFO_CNT_BITS'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o     = count_q;
    assign head_data_o = data_q[rd_ptr_q];
    assign head_last_o = last_q[rd_ptr_q];

endmodule

// File: rtl/gbuff_reader.sv
// Global-buffer read initiator: walks base + k*stride for length words, issues
// one read per address and streams the returned words out with backpressure.
module gbuff_reader
    import gbuff_pkg::*;
#(
    parameter int ADDR_BITS = GB_ADDR_BITS,
    parameter int DATA_BITS = GB_DATA_BITS,
    parameter int LEN_BITS  = ADDR_BITS + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS-1:0] stride,
    input  logic [LEN_BITS-1:0]  length,
    output logic                 gb_wr_en,
    output logic [ADDR_BITS-1:0] gb_index,
    input  logic [DATA_BITS-1:0] gb_rdata,
    output logic                 out_valid,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);

    state_t                   state_q, state_d;
    logic [ADDR_BITS-1:0]     addr_q, addr_d;
    logic [ADDR_BITS-1:0]     stride_q, stride_d;
    logic [ADDR_BITS-1:0]     index_q, index_d;
    logic [LEN_BITS-1:0]      remain_q, remain_d;
    logic                     inflight_q, inflight_d;
    logic                     inflight_last_q, inflight_last_d;
    logic                     done_q, done_d;

    logic [FIFO_CNT_BITS-1:0] fifo_count;
    logic [DATA_BITS-1:0]     fifo_data;
    logic                     fifo_last;
    logic                     pop;
    logic                     issue_ok;
    logic [OCC_BITS-1:0]      occupancy;

    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_data : '0;
    assign out_last  = out_valid & fifo_last;
    assign pop       = out_valid & out_ready;

    // Words held or in flight after this edge must never exceed the FIFO depth.
    assign occupancy = OCC_BITS'(fifo_count) + OCC_BITS'(inflight_q);
    assign issue_ok  = occupancy < (OCC_BITS'(FIFO_DEPTH) + OCC_BITS'(pop));

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        stride_d        = stride_q;
        remain_d        = remain_q;
        index_d         = index_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        done_d          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d   = base_addr;
                        stride_d = stride;
                        remain_d = length;
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (issue_ok) begin
                    index_d         = addr_q;
                    addr_d          = addr_q + stride_q;
                    remain_d        = remain_q - LEN_BITS'(1);
                    inflight_d      = 1'b1;
                    inflight_last_d = (remain_q == LEN_BITS'(1));
                    if (remain_q == LEN_BITS'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            stride_q        <= '0;
            remain_q        <= '0;
            index_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            stride_q        <= stride_d;
            remain_q        <= remain_d;
            index_q         <= index_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    // The word addressed last cycle is on gb_rdata now; capture it this edge.
    gbuff_skid_fifo #(
        .DATA_BITS (DATA_BITS)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (gb_rdata),
        .push_last_i (inflight_last_q),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .head_data_o (fifo_data),
        .head_last_o (fifo_last)
    );

    assign gb_wr_en = 1'b0;
    assign gb_index = index_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_gbuff_reader.sv
// Directed bench for gbuff_reader: expected words are queued at stimulus time
// and a negedge monitor compares every accepted stream word against the queue.
`timescale 1ns/1ps
module tb_gbuff_reader;

    localparam int AB = 8;
    localparam int DB = 8;
    localparam int LB = 9;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AB-1:0] base_addr = '0;
    logic [AB-1:0] stride = '0;
    logic [LB-1:0] length = '0;
    logic          gb_wr_en;
    logic [AB-1:0] gb_index;
    logic [DB-1:0] gb_rdata = '0;
    logic          out_valid;
    logic [DB-1:0] out_data;
    logic          out_last;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;

    logic [DB-1:0] gbuff [256];
    exp_t          exp_q[$];
    exp_t          e_pop;
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    bit            ready_toggle = 1'b0;
    bit            track_outstanding = 1'b0;
    int            accepted_cnt = 0;
    int            issued_cnt = 0;
    logic [AB-1:0] prev_index = '0;
    bit            held_valid = 1'b0;
    logic [DB-1:0] held_data = '0;
    logic          held_last = 1'b0;
    logic [AB-1:0] t2_idx [4] = '{8'd250, 8'd253, 8'd0, 8'd3};

    gbuff_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .stride    (stride),
        .length    (length),
        .gb_wr_en  (gb_wr_en),
        .gb_index  (gb_index),
        .gb_rdata  (gb_rdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: index sampled at negedge, data captured by the DUT next posedge.
    always @(negedge clk) gb_rdata = gbuff[gb_index];

    always @(posedge clk) begin
        #1;
        if (ready_toggle) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        else              out_ready = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int v, input bit last);
        exp_t e;
        e.data = DB'(v);
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Drives a start strobe; returns just after the accepting posedge.
    task automatic start_cmd(input logic [AB-1:0] b, input logic [AB-1:0] s, input logic [LB-1:0] l);
        base_addr = b;
        stride    = s;
        length    = l;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done_timeout: done still %0b after %0d cycles, expected 1", name, done, max_cyc);
        end
        check({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (track_outstanding) begin
            if (gb_index != prev_index) issued_cnt++;
            check("outstanding_le2", 32'((issued_cnt - accepted_cnt) <= 2), 1);
        end
        prev_index = gb_index;
        if (held_valid) begin
            check("stall_valid_held", out_valid, 1);
            check("stall_data_stable", out_data, held_data);
            check("stall_last_stable", out_last, held_last);
        end
        held_valid = out_valid && !out_ready && !rst;
        held_data  = out_data;
        held_last  = out_last;
        if (out_valid && out_ready) begin
            accepted_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got data %0d with none expected", out_data);
            end else begin
                e_pop = exp_q.pop_front();
                check("word_data", out_data, e_pop.data);
                check("word_last", out_last, e_pop.last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) gbuff[i] = DB'(i);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_index", gb_index, 0);
        check("rst_wr_en", gb_wr_en, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: base 4, stride 1, length 5, cycle-accurate latency
        for (int i = 0; i < 5; i++) push_exp(4 + i, i == 4);
        start_cmd(8'd4, 8'd1, 9'd5);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            check("t1_valid", out_valid, 32'(k >= 2 && k <= 6));
            check("t1_last", out_last, 32'(k == 6));
            check("t1_done", done, 32'(k == 7));
            check("t1_busy", busy, 32'(k <= 6));
            if (k == 1) check("t1_first_index", gb_index, 4);
        end
        check("t1_sb_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // 2: wrapping stride
        push_exp(250, 1'b0);
        push_exp(253, 1'b0);
        push_exp(0, 1'b0);
        push_exp(3, 1'b1);
        start_cmd(8'd250, 8'd3, 9'd4);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) @(negedge clk);
            check("t2_index", gb_index, t2_idx[k-1]);
        end
        wait_done("t2", 20);
        @(posedge clk);
        #1;

        // 3: zero length
        start_cmd(8'd77, 8'd1, 9'd0);
        @(negedge clk);
        check("t3_done", done, 1);
        check("t3_busy", busy, 0);
        check("t3_valid", out_valid, 0);
        check("t3_index", gb_index, 3);
        @(negedge clk);
        check("t3_done_pulse", done, 0);
        check("t3_busy_low", busy, 0);
        check("t3_index_held", gb_index, 3);
        @(posedge clk);
        #1;

        // 4: toggled backpressure
        ready_toggle = 1'b1;
        accepted_cnt = 0;
        issued_cnt = 0;
        track_outstanding = 1'b1;
        for (int i = 0; i < 6; i++) push_exp(10 + i, i == 5);
        start_cmd(8'd10, 8'd1, 9'd6);
        wait_done("t4", 60);
        track_outstanding = 1'b0;
        check("t4_issued", issued_cnt, 6);
        check("t4_accepted", accepted_cnt, 6);
        @(posedge clk);
        #1 ready_toggle = 1'b0;
        @(posedge clk);
        #1;

        // 5: second start while busy is ignored
        for (int i = 0; i < 6; i++) push_exp(20 + 2 * i, i == 5);
        start_cmd(8'd20, 8'd2, 9'd6);
        repeat (2) @(posedge clk);
        #1;
        start_cmd(8'd100, 8'd1, 9'd3);
        wait_done("t5", 30);
        repeat (4) @(negedge clk);
        check("t5_no_extra_valid", out_valid, 0);
        check("t5_idle", busy, 0);
        @(posedge clk);
        #1;

        // 6: reset mid-transfer, then a fresh transfer
        accepted_cnt = 0;
        for (int i = 0; i < 8; i++) push_exp(30 + i, i == 7);
        start_cmd(8'd30, 8'd1, 9'd8);
        for (int n = 0; n < 20 && accepted_cnt < 3; n++) @(negedge clk);
        check("t6_three_accepted", 32'(accepted_cnt >= 3), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_data", out_data, 0);
        check("t6_rst_last", out_last, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_index", gb_index, 0);
        check("t6_rst_wr_en", gb_wr_en, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6_no_done", done, 0);
            check("t6_no_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) push_exp(40 + 5 * i, i == 2);
        start_cmd(8'd40, 8'd5, 9'd3);
        wait_done("t6_fresh", 20);
        check("t6_wr_en", gb_wr_en, 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
